// File: rtl/matrix_row_driver.sv
// matrix_row_driver
// Captures a 6-cell (3 rows x 2 columns) colour frame from the cell colour
// encoder into a shadow buffer, commits it to a display buffer at row
// blanking boundaries, and scans a row-multiplexed active-low RGB matrix.
// Optional build macro: DIM_PWM_EN adds a 4-bit brightness input that
// PWM-gates the colour drive during each row's dwell period.
module matrix_row_driver #(
    parameter int DWELL     = 1000,
    parameter int BLANK_CYC = 16,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] in_sel,
    input  logic [2:0] in_col,
    input  logic       in_valid,
`ifdef DIM_PWM_EN
    input  logic [3:0] brightness,
`endif
    output logic [2:0] row_n,
    output logic [1:0] col_r,
    output logic [1:0] col_g,
    output logic [1:0] col_b,
    output logic       frame_tick
);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       row_q, row_d;
    logic             pend_q, pend_d;
    logic [2:0]       shadow_q [6];
    logic [2:0]       shadow_d [6];
    logic [2:0]       disp_q   [6];
    logic [2:0]       disp_d   [6];
    logic [2:0]       row_n_q, row_n_d;
    logic [1:0]       col_r_q, col_r_d;
    logic [1:0]       col_g_q, col_g_d;
    logic [1:0]       col_b_q, col_b_d;
    logic             tick_q, tick_d;

    logic             wr_en;
    logic             wr_last;
    logic             enter_blank;
    logic             enter_drive;
    logic             commit;
    logic [2:0]       cell_lo;
    logic [2:0]       cell_hi;

`ifdef DIM_PWM_EN
    logic [3:0]       phase_q, phase_d;
    logic [3:0]       bright_q, bright_d;
`endif

    // Scan FSM next state: per-state counter, row advance on leaving DRIVE
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        row_d       = row_q;
        enter_blank = 1'b0;
        enter_drive = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    enter_drive = 1'b1;
                    state_d     = ST_DRIVE;
                    cnt_d       = '0;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == DWELL_LAST) begin
                    enter_blank = 1'b1;
                    state_d     = ST_BLANK;
                    cnt_d       = '0;
                    row_d       = (row_q == 2'd2) ? 2'd0 : row_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // Capture and commit: the commit copies shadow as it stood before this
    // edge, so a coincident index-5 write re-arms the pending flag instead
    always_comb begin
        wr_en   = in_valid && (in_sel <= 6'd5);
        wr_last = wr_en && (in_sel == 6'd5);
        commit  = enter_blank && pend_q;
        for (int unsigned i = 0; i < 6; i++) begin
            shadow_d[i] = shadow_q[i];
            disp_d[i]   = disp_q[i];
            if (wr_en && (in_sel == 6'(i))) begin
                shadow_d[i] = in_col;
            end
            if (commit) begin
                disp_d[i] = shadow_q[i];
            end
        end
        pend_d = commit ? wr_last : (pend_q || wr_last);
    end

`ifdef DIM_PWM_EN
    // PWM phase and brightness sample, both restarting at DRIVE entry
    always_comb begin
        phase_d  = phase_q;
        bright_d = bright_q;
        if (enter_drive) begin
            phase_d  = '0;
            bright_d = brightness;
        end else if (state_q == ST_DRIVE) begin
            phase_d  = phase_q + 4'd1;
        end
    end
`endif

    // Registered outputs are derived from next state so they line up with
    // the state register; display is stable whenever state_d is DRIVE
    always_comb begin
        row_n_d = '1;
        col_r_d = '0;
        col_g_d = '0;
        col_b_d = '0;
        tick_d  = enter_blank && (row_q == 2'd2);
        case (row_d)
            2'd0:    begin cell_lo = disp_q[0]; cell_hi = disp_q[1]; end
            2'd1:    begin cell_lo = disp_q[2]; cell_hi = disp_q[3]; end
            default: begin cell_lo = disp_q[4]; cell_hi = disp_q[5]; end
        endcase
        if (state_d == ST_DRIVE) begin
            case (row_d)
                2'd0:    row_n_d = 3'b110;
                2'd1:    row_n_d = 3'b101;
                default: row_n_d = 3'b011;
            endcase
            col_r_d = {cell_hi[2], cell_lo[2]};
            col_g_d = {cell_hi[1], cell_lo[1]};
            col_b_d = {cell_hi[0], cell_lo[0]};
`ifdef DIM_PWM_EN
            if (phase_d >= bright_d) begin
                col_r_d = '0;
                col_g_d = '0;
                col_b_d = '0;
            end
`endif
        end
    end

    // State, buffers and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            row_q   <= '0;
            pend_q  <= 1'b0;
            for (int unsigned i = 0; i < 6; i++) begin
                shadow_q[i] <= '0;
                disp_q[i]   <= '0;
            end
            row_n_q <= '1;
            col_r_q <= '0;
            col_g_q <= '0;
            col_b_q <= '0;
            tick_q  <= 1'b0;
`ifdef DIM_PWM_EN
            phase_q  <= '0;
            bright_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            pend_q  <= pend_d;
            for (int unsigned i = 0; i < 6; i++) begin
                shadow_q[i] <= shadow_d[i];
                disp_q[i]   <= disp_d[i];
            end
            row_n_q <= row_n_d;
            col_r_q <= col_r_d;
            col_g_q <= col_g_d;
            col_b_q <= col_b_d;
            tick_q  <= tick_d;
`ifdef DIM_PWM_EN
            phase_q  <= phase_d;
            bright_q <= bright_d;
`endif
        end
    end

    assign row_n      = row_n_q;
    assign col_r      = col_r_q;
    assign col_g      = col_g_q;
    assign col_b      = col_b_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_matrix_row_driver.sv
// Directed bench for matrix_row_driver with DWELL=4, BLANK_CYC=2.
module tb_matrix_row_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] in_sel = '0;
    logic [2:0] in_col = '0;
    logic       in_valid = 1'b0;
`ifdef DIM_PWM_EN
    logic [3:0] brightness = 4'd15;
`endif
    logic [2:0] row_n;
    logic [1:0] col_r, col_g, col_b;
    logic       frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    matrix_row_driver #(
        .DWELL(4),
        .BLANK_CYC(2),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_sel(in_sel),
        .in_col(in_col),
        .in_valid(in_valid),
`ifdef DIM_PWM_EN
        .brightness(brightness),
`endif
        .row_n(row_n),
        .col_r(col_r),
        .col_g(col_g),
        .col_b(col_b),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [5:0] sel, input logic [2:0] col, input logic vld);
        in_sel   = sel;
        in_col   = col;
        in_valid = vld;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            if (frame_tick) seen = 1'b1;
        end
        if (!seen) check("tick_wait", {15'd0, frame_tick}, 16'd1);
    endtask

    // Called on the frame_tick cycle; expected values are {r[1:0],g[1:0],b[1:0]}
    task automatic check_frame(input string tag, input logic [5:0] e0,
                               input logic [5:0] e1, input logic [5:0] e2);
        step(); step();
        check({tag, "_row0"}, {7'd0, row_n, col_r, col_g, col_b}, {7'd0, 3'b110, e0});
        repeat (6) step();
        check({tag, "_row1"}, {7'd0, row_n, col_r, col_g, col_b}, {7'd0, 3'b101, e1});
        repeat (6) step();
        check({tag, "_row2"}, {7'd0, row_n, col_r, col_g, col_b}, {7'd0, 3'b011, e2});
    endtask

    // Starts on the cycle reset is released; display is expected empty
    task automatic scan_check(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            int         ph;
            logic [2:0] exp_row;
            logic       exp_tick;
            ph       = k % 18;
            exp_row  = ((ph % 6) < 2) ? 3'b111 : ~(3'b001 << (ph / 6));
            exp_tick = (k != 0) && (ph == 0);
            check(tag, {6'd0, row_n, frame_tick, col_r, col_g, col_b},
                  {6'd0, exp_row, exp_tick, 6'b000000});
            step();
        end
    endtask

    initial begin
        // Reset held
        repeat (3) step();
        check("reset_hold", {6'd0, row_n, frame_tick, col_r, col_g, col_b},
              {6'd0, 3'b111, 1'b0, 6'b000000});
        rst_n = 1'b1;
        scan_check("scan", 40);

        // Frame load: 1,0,2,4,7,6
        put(6'd0, 3'd1, 1'b1);
        put(6'd1, 3'd0, 1'b1);
        put(6'd2, 3'd2, 1'b1);
        put(6'd3, 3'd4, 1'b1);
        put(6'd4, 3'd7, 1'b1);
        put(6'd5, 3'd6, 1'b1);
        wait_tick();
        check_frame("load", 6'b00_00_01, 6'b10_01_00, 6'b11_11_01);

        // Cells 0..4 rewritten without index 5: no commit over two frames
        for (int s = 0; s < 5; s++) put(6'(s), 3'd7, 1'b1);
        wait_tick();
        check_frame("nocommit_a", 6'b00_00_01, 6'b10_01_00, 6'b11_11_01);
        wait_tick();
        check_frame("nocommit_b", 6'b00_00_01, 6'b10_01_00, 6'b11_11_01);
        put(6'd5, 3'd1, 1'b1);
        wait_tick();
        check_frame("commit5", 6'b11_11_11, 6'b11_11_11, 6'b01_01_11);

        // Legal cell-0 write without index 5, then ignored beats
        put(6'd0, 3'd2, 1'b1);
        put(6'd6, 3'd0, 1'b1);
        put(6'd63, 3'd0, 1'b1);
        put(6'd13, 3'd0, 1'b1);
        put(6'd8, 3'd0, 1'b1);
        put(6'd0, 3'd0, 1'b0);
        put(6'd5, 3'd0, 1'b0);
        wait_tick();
        check_frame("ignored_a", 6'b11_11_11, 6'b11_11_11, 6'b01_01_11);
        wait_tick();
        check_frame("ignored_b", 6'b11_11_11, 6'b11_11_11, 6'b01_01_11);
        put(6'd5, 3'd1, 1'b1);
        wait_tick();
        check_frame("after_ignored", 6'b10_11_10, 6'b11_11_11, 6'b01_01_11);

        // Uncommitted data then reset in the middle of a DRIVE period
        for (int s = 0; s < 5; s++) put(6'(s), 3'd7, 1'b1);
        begin
            bit in_drive = 1'b0;
            for (int i = 0; i < 50 && !in_drive; i++) begin
                step();
                if (row_n != 3'b111) in_drive = 1'b1;
            end
            check("drive_wait", {15'd0, in_drive}, 16'd1);
        end
        step();
        rst_n = 1'b0;
        #1;
        check("reset_async", {6'd0, row_n, frame_tick, col_r, col_g, col_b},
              {6'd0, 3'b111, 1'b0, 6'b000000});
        step();
        rst_n = 1'b1;
        scan_check("scan_after_reset", 20);
        put(6'd5, 3'd5, 1'b1);
        wait_tick();
        check_frame("shadow_lost", 6'b00_00_00, 6'b00_00_00, 6'b10_00_10);

`ifdef DIM_PWM_EN
        // brightness=2 over a 4-cycle dwell: on for phases 0,1 only
        brightness = 4'd2;
        for (int s = 0; s < 6; s++) put(6'(s), 3'd7, 1'b1);
        wait_tick();
        step(); step();
        for (int p = 0; p < 4; p++) begin
            check("pwm_b2", {7'd0, row_n, col_r, col_g, col_b},
                  {7'd0, 3'b110, (p < 2) ? 6'b11_11_11 : 6'b00_00_00});
            step();
        end
        brightness = 4'd0;
        wait_tick();
        step(); step();
        for (int p = 0; p < 4; p++) begin
            check("pwm_b0", {7'd0, row_n, col_r, col_g, col_b},
                  {7'd0, 3'b110, 6'b00_00_00});
            step();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
